i2c_bit_sequencer: RTL
======================

Name: i2c_bit_sequencer

Overview:
- Bit-level I2C master controller that schedules the four-quarter SCL bit period. Each bit is split into quarter phases 0..3, in the same scheme as the team's quarter-phase clock generator.
- Accepts one bus command (START, STOP, WRITE bit, READ bit) per handshake and drives open-drain SCL/SDA enables phase by phase.
- Samples SDA, honours clock stretching and detects arbitration loss.
- Sits between the byte-level translator FSM (above) and the pad open-drain buffers (below).

Parameters:
- QTR_DIV, 4, clk cycles per quarter phase; legal range 2..255.
- CW, $clog2(QTR_DIV), width of the quarter-cycle counter (derived, not overridden).

Ports:
- clk  in  1  system clock, all flops on posedge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd  in  2  00=START, 01=STOP, 10=WRITE, 11=READ
- din  in  1  bit to transmit for WRITE
- dout  out  1  bit sampled by READ; valid when done=1
- done  out  1  one-cycle pulse, command complete
- arb_lost  out  1  one-cycle pulse, arbitration lost
- busy  out  1  command in progress
- bus_owned  out  1  set by START, cleared by STOP or arb loss
- phase  out  2  current quarter phase (debug)
- scl_in  in  1  raw SCL pad level (async)
- sda_in  in  1  raw SDA pad level (async)
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - scl_oe=0, sda_oe=0, bus_owned=0, busy=0, done=0, arb_lost=0, dout=0, phase=0, quarter counter=0, synchronisers cleared to 1.
  - Reset mid-command aborts immediately with the bus released; no done pulse.
- Synchronisation: scl_in and sda_in each pass through a 2-flop synchroniser (scl_s, sda_s) before any use.
- States: IDLE, RUN.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&&cmd_ready: latch cmd/din, enter RUN with phase=0 and counter=0.
- RUN:
  - cmd_ready=0, busy=1.
  - Counter increments each cycle. At QTR_DIV-1 the counter wraps to 0 and phase increments.
- Clock stretching: in phases 1 and 2, while scl_oe=0 and scl_s=0, the counter holds. Stretch cycles add directly to latency.
- Completion:
  - done=1 in the last cycle of phase 3 (counter=QTR_DIV-1).
  - Next cycle is IDLE, so back-to-back commands start one cycle after done.
  - Unstretched latency is accept edge to done cycle = 4*QTR_DIV cycles.
- Per-phase output levels (oe=1 means driven low), registered, applied from the first cycle of each phase:
  - START: ph0 scl=0 sda=0 (released); ph1 scl=0 sda=0; ph2 scl=0 sda=1; ph3 scl=1 sda=1. Sets bus_owned with done.
  - STOP: ph0 scl=1 sda=1; ph1 scl=0 sda=1; ph2 scl=0 sda=1; ph3 scl=0 sda=0. Clears bus_owned with done.
  - WRITE: sda_oe=~din in all phases; scl_oe ph0=1, ph1=0, ph2=0, ph3=1.
  - READ: sda_oe=0 in all phases; scl same as WRITE. dout<=sda_s in the last cycle of phase 2.
- Arbitration:
  - Condition: WRITE with din=1 and sda_s=0 in the last cycle of phase 2.
  - Response: arb_lost pulses, done pulses in the same cycle, bus_owned<=0, scl_oe=sda_oe=0, and the state returns to IDLE without running phase 3.
- Outputs in IDLE:
  - scl_oe holds 1 if bus_owned, else 0.
  - sda_oe holds its last driven value. It is 0 after STOP, arb loss or reset.
- Illegal sequencing (e.g. WRITE with bus_owned=0) is executed as commanded. Checking it is the upstream FSM's job.

Decomposition:
- Package i2c_pkg holds:
  - cmd encodings CMD_START/CMD_STOP/CMD_WRITE/CMD_READ
  - state enum {IDLE, RUN}
  - phase constants PH0..PH3
- Sub-module i2c_sync2: parameterless 2-flop synchroniser on clk/rst with reset value 1. Instantiate it twice.

Test Plan:
1. QTR_DIV=4, START from reset idle.
   - Required: cmd_ready drops; sda_oe rises at start of ph2 with scl_oe=0; scl_oe rises at ph3.
   - done 16 cycles after accept; bus_owned=1; cmd_ready=1 next cycle.
2. WRITE din=0, then WRITE din=1, back-to-back with cmd_valid held.
   - Required: second accept one cycle after first done.
   - scl_oe pattern 1,0,0,1 per quarter; sda_oe=1 then 0.
3. READ with sda_in=0, then READ with sda_in=1, settled before ph2.
   - Required: dout=0 then dout=1 with each done; sda_oe=0 throughout.
4. WRITE din=0, with scl_in forced low for 10 cycles from the start of ph1.
   - Required: phase stays 1 while scl_s=0; done at 26 cycles after accept.
5. WRITE din=1 with sda_in forced 0.
   - Required: arb_lost and done pulse together at end of ph2 (12 cycles after accept).
   - scl_oe=sda_oe=0, bus_owned=0, phase-3 drive never issued.
6. Assert rst=0 mid-ph1 of STOP.
   - Required: scl_oe, sda_oe, busy, bus_owned all 0 immediately without a clock edge; no done.
   - After release, cmd_ready=1.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C bit sequencer.
// Command codes, FSM states, quarter phases and per-phase pad drive levels.
package i2c_pkg;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Returns {scl_oe, sda_oe}; 1 pulls the line low.
  function automatic logic [1:0] drive_lvl(
    input logic [1:0] c,
    input logic       d,
    input logic [1:0] ph
  );
    logic scl_low;
    logic [1:0] lvl;
    scl_low = (ph == PH0) || (ph == PH3);
    lvl = 2'b00;
    unique case (c)
      CMD_START: begin
        lvl = {ph == PH3, ph[1]};
      end
      CMD_STOP: begin
        lvl = {ph == PH0, ph != PH3};
      end
      CMD_WRITE: begin
        lvl = {scl_low, ~d};
      end
      CMD_READ: begin
        lvl = {scl_low, 1'b0};
      end
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchroniser for an asynchronous pad input.
// Resets to 1, the idle level of an open-drain I2C line.
module i2c_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/i2c_bit_sequencer.sv
// Bit-level I2C master: runs one START/STOP/WRITE/READ command
// over four quarter phases, with stretching and arbitration detect.
module i2c_bit_sequencer
  import i2c_pkg::*;
#(
  parameter int QTR_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       din,
  output logic       dout,
  output logic       done,
  output logic       arb_lost,
  output logic       busy,
  output logic       bus_owned,
  output logic [1:0] phase,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int CW = $clog2(QTR_DIV);

  logic scl_s;
  logic sda_s;

  i2c_sync2 u_scl_sync (.clk(clk), .rst(rst), .d(scl_in), .q(scl_s));
  i2c_sync2 u_sda_sync (.clk(clk), .rst(rst), .d(sda_in), .q(sda_s));

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      phase_q, phase_d;
  logic [1:0]      cmd_q, cmd_d;
  logic            din_q, din_d;
  logic            scl_oe_q, scl_oe_d;
  logic            sda_oe_q, sda_oe_d;
  logic            owned_q, owned_d;
  logic            dout_q, dout_d;

  logic stretch;
  logic end_ph;
  logic arb_c;
  logic [1:0] lvl;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    cmd_d    = cmd_q;
    din_d    = din_q;
    scl_oe_d = scl_oe_q;
    sda_oe_d = sda_oe_q;
    owned_d  = owned_q;
    dout_d   = dout_q;
    lvl      = 2'b00;

    // A slave holding SCL low while we release it freezes the quarter.
    stretch = (state_q == RUN)
            && ((phase_q == PH1) || (phase_q == PH2))
            && !scl_oe_q && !scl_s;
    end_ph  = (state_q == RUN) && !stretch
            && (cnt_q == CW'(QTR_DIV - 1));
    arb_c   = end_ph && (phase_q == PH2)
            && (cmd_q == CMD_WRITE) && din_q && !sda_s;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = RUN;
          cmd_d   = cmd;
          din_d   = din;
          cnt_d   = '0;
          phase_d = PH0;
          lvl     = drive_lvl(cmd, din, PH0);
          scl_oe_d = lvl[1];
          sda_oe_d = lvl[0];
        end
      end
      RUN: begin
        if (!stretch) begin
          cnt_d = end_ph ? '0 : cnt_q + CW'(1);
        end
        if (end_ph) begin
          phase_d = phase_q + 2'd1;
          if ((phase_q == PH2) && (cmd_q == CMD_READ)) begin
            dout_d = sda_s;
          end
          if (arb_c) begin
            state_d  = IDLE;
            phase_d  = PH0;
            owned_d  = 1'b0;
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
          end else if (phase_q == PH3) begin
            state_d = IDLE;
            if (cmd_q == CMD_START) begin
              owned_d = 1'b1;
            end else if (cmd_q == CMD_STOP) begin
              owned_d = 1'b0;
            end
            scl_oe_d = owned_d;
          end else begin
            lvl      = drive_lvl(cmd_q, din_q, phase_q + 2'd1);
            scl_oe_d = lvl[1];
            sda_oe_d = lvl[0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      phase_q  <= PH0;
      cmd_q    <= CMD_START;
      din_q    <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      owned_q  <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      cmd_q    <= cmd_d;
      din_q    <= din_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      owned_q  <= owned_d;
      dout_q   <= dout_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (end_ph && (phase_q == PH3)) || arb_c;
  assign arb_lost  = arb_c;
  assign bus_owned = owned_q;
  assign phase     = phase_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  assign dout      = dout_q;

endmodule
